// File: rtl/key_schedule_gen_if.sv
// Bus bundle between a round-key consumer and key_schedule_gen.
// Handshake: start is taken only while the generator is idle and not busy (otherwise it is dropped).
// rk_valid is a one-cycle strobe with no ready and no backpressure, so the consumer takes every strobe.
interface key_schedule_gen_if #(
  parameter int NK = 4
);
  logic             start;
  logic [32*NK-1:0] key_in;
  logic [127:0]     rk_out;
  logic             rk_valid;
  logic [3:0]       rk_index;
  logic             busy;
  logic             done;

  modport master (output start, key_in, input rk_out, rk_valid, rk_index, busy, done);
  modport slave  (input start, key_in, output rk_out, rk_valid, rk_index, busy, done);
endinterface

// File: rtl/key_schedule_gen.sv
// AES key-schedule generator (AES-128/192/256 via NK) streaming round keys 0..Nr,
// using one byte-serial S-box with a registered output.
module sbox (
  input  logic       clk,
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);
  logic [7:0] r_out;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      t = gf_xtime(t);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), followed by the FIPS-197 affine map.
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] b;
    r = a;
    for (int k = 0; k < 6; k++) r = gf_mul(gf_mul(r, r), a);
    b = gf_mul(r, r);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  always_ff @(posedge clk) begin
    r_out <= sbox_f(i_in);
  end

  assign o_out = r_out;
endmodule

module key_schedule_gen #(
  parameter int NK = 4
) (
  input  logic               clk,
  input  logic               rst,
  key_schedule_gen_if.slave  bus,
  output logic [1:0]         o_state
);
  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("key_schedule_gen: NK must be 4, 6 or 8");
  end

  localparam logic [5:0] I_FIRST   = 6'(NK);
  localparam logic [5:0] I_LAST    = 6'(4 * (NK + 7) - 1);
  localparam logic [2:0] IMOD_LAST = 3'(NK - 1);
  localparam logic       INIT_LAST = (NK == 8) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_SUB  = 2'd2,
    ST_GEN  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [31:0]  r_w [NK];
  logic [5:0]   r_i;
  logic [2:0]   r_imod;
  logic [2:0]   r_cnt;
  logic         r_j;
  logic [7:0]   r_rcon;
  logic [31:0]  r_s;
  logic [127:0] r_rk_out;
  logic [3:0]   r_rk_index;
  logic         r_rk_valid;
  logic         r_done;

  logic         w_accept;
  logic [31:0]  w_newest;
  logic [31:0]  w_x;
  logic [7:0]   w_sbox_in;
  logic [7:0]   w_sbox_out;
  logic [31:0]  w_t;
  logic [31:0]  w_new;
  logic [2:0]   w_imod_nxt;
  logic [7:0]   w_rcon_nxt;
  logic [127:0] w_init_rk;

  function automatic logic needs_sub(input logic [2:0] imod);
    return (imod == 3'd0) || ((NK == 8) && (imod == 3'd4));
  endfunction

  // Start is dropped in the done cycle too, so a new run begins no earlier than the cycle after done.
  assign w_accept   = (r_state == ST_IDLE) && bus.start && !r_done;
  assign w_newest   = r_w[NK-1];
  assign w_x        = (r_imod == 3'd0) ? {w_newest[23:0], w_newest[31:24]} : w_newest;
  assign w_sbox_in  = w_x[{r_cnt[1:0], 3'b000} +: 8];
  assign w_imod_nxt = (r_imod == IMOD_LAST) ? 3'd0 : r_imod + 3'd1;
  assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  always_comb begin
    w_t = w_newest;
    if (r_imod == 3'd0) w_t = r_s ^ {r_rcon, 24'h000000};
    else if ((NK == 8) && (r_imod == 3'd4)) w_t = r_s;
  end

  assign w_new = r_w[0] ^ w_t;

  if (NK == 8) begin : g_init_two
    assign w_init_rk = r_j ? {r_w[7], r_w[6], r_w[5], r_w[4]}
                           : {r_w[3], r_w[2], r_w[1], r_w[0]};
  end else begin : g_init_one
    assign w_init_rk = {r_w[3], r_w[2], r_w[1], r_w[0]};
  end

  sbox u_sbox (
    .clk   (clk),
    .i_in  (w_sbox_in),
    .o_out (w_sbox_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_INIT;
      ST_INIT: if (r_j == INIT_LAST) w_state_nxt = needs_sub(r_imod) ? ST_SUB : ST_GEN;
      ST_SUB:  if (r_cnt == 3'd4) w_state_nxt = ST_GEN;
      ST_GEN: begin
        if (r_i == I_LAST) w_state_nxt = ST_IDLE;
        else w_state_nxt = needs_sub(w_imod_nxt) ? ST_SUB : ST_GEN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      for (int k = 0; k < NK; k++) r_w[k] <= '0;
      r_i        <= I_FIRST;
      r_imod     <= 3'd0;
      r_cnt      <= 3'd0;
      r_j        <= 1'b0;
      r_rcon     <= 8'h01;
      r_s        <= '0;
      r_rk_out   <= '0;
      r_rk_index <= 4'd0;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            for (int k = 0; k < NK; k++) r_w[k] <= bus.key_in[32*k +: 32];
            r_i    <= I_FIRST;
            r_imod <= 3'd0;
            r_rcon <= 8'h01;
            r_j    <= 1'b0;
            r_cnt  <= 3'd0;
          end
        end
        ST_INIT: begin
          r_rk_out   <= w_init_rk;
          r_rk_index <= {3'b000, r_j};
          r_rk_valid <= 1'b1;
          r_j        <= r_j + 1'b1;
        end
        ST_SUB: begin
          // S-box result lags its select by one cycle, so byte k-1 lands at cnt k.
          case (r_cnt)
            3'd1: r_s[7:0]   <= w_sbox_out;
            3'd2: r_s[15:8]  <= w_sbox_out;
            3'd3: r_s[23:16] <= w_sbox_out;
            3'd4: r_s[31:24] <= w_sbox_out;
            default: ;
          endcase
          r_cnt <= (r_cnt == 3'd4) ? 3'd0 : r_cnt + 3'd1;
        end
        ST_GEN: begin
          for (int k = 0; k < NK - 1; k++) r_w[k] <= r_w[k+1];
          r_w[NK-1] <= w_new;
          r_i       <= r_i + 6'd1;
          r_imod    <= w_imod_nxt;
          if (r_imod == 3'd0) r_rcon <= w_rcon_nxt;
          if (r_i[1:0] == 2'd3) begin
            r_rk_out   <= {w_new, r_w[NK-1], r_w[NK-2], r_w[NK-3]};
            r_rk_index <= r_i[5:2];
            r_rk_valid <= 1'b1;
          end
          if (r_i == I_LAST) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rk_out   = r_rk_out;
  assign bus.rk_index = r_rk_index;
  assign bus.rk_valid = r_rk_valid;
  assign bus.done     = r_done;
  assign bus.busy     = (r_state != ST_IDLE) || r_done;
  assign o_state      = r_state;
endmodule

// File: tb/tb_key_schedule_gen.sv
// Bench for key_schedule_gen: FIPS-197 key expansions for NK=4/6/8 plus reset,
// ignored-start and back-to-back sequences on the NK=4 instance.
module tb_key_schedule_gen;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_schedule_gen_if #(.NK(4)) bus4 ();
  key_schedule_gen_if #(.NK(6)) bus6 ();
  key_schedule_gen_if #(.NK(8)) bus8 ();
  logic [1:0] st4, st6, st8;

  key_schedule_gen #(.NK(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave), .o_state(st4));
  key_schedule_gen #(.NK(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave), .o_state(st6));
  key_schedule_gen #(.NK(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave), .o_state(st8));

  localparam logic [127:0] KEY4  = {32'h09cf4f3c, 32'habf71588, 32'h28aed2a6, 32'h2b7e1516};
  localparam logic [127:0] BOGUS = {32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'hfeedface};
  localparam logic [191:0] KEY6  = {32'h522c6b7b, 32'h62f8ead2, 32'h809079e5,
                                    32'hc810f32b, 32'hda0e6452, 32'h8e73b0f7};
  localparam logic [255:0] KEY8  = {32'h0914dff4, 32'h2d9810a3, 32'h3b6108d7, 32'h1f352c07,
                                    32'h857d7781, 32'h2b73aef0, 32'h15ca71be, 32'h603deb10};

  typedef struct {
    int           nk;
    int           round;
    int           word;   // -1 compares the whole 128-bit round key and its index
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [20];

  int n_checks = 0;
  int n_fail   = 0;

  // Strobe log per instance (0: NK=4, 1: NK=6, 2: NK=8)
  logic [127:0] g_rk  [3][64];
  logic [3:0]   g_ix  [3][64];
  int           g_cyc [3][64];
  int           n_st  [3];
  int           dcyc  [3][4];
  int           n_done[3];

  task automatic record(input int d, input logic v, input logic dn,
                        input logic [127:0] rk, input logic [3:0] ix);
    if (v) begin
      if (n_st[d] < 64) begin
        g_rk[d][n_st[d]]  = rk;
        g_ix[d][n_st[d]]  = ix;
        g_cyc[d][n_st[d]] = cyc;
      end
      n_st[d]++;
    end
    if (dn) begin
      if (n_done[d] < 4) dcyc[d][n_done[d]] = cyc;
      n_done[d]++;
    end
  endtask

  always @(negedge clk) begin
    record(0, bus4.rk_valid, bus4.done, bus4.rk_out, bus4.rk_index);
    record(1, bus6.rk_valid, bus6.done, bus6.rk_out, bus6.rk_index);
    record(2, bus8.rk_valid, bus8.done, bus8.rk_out, bus8.rk_index);
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_table(input int nk, input int d, input int base, input string tag);
    int e;
    for (int v = 0; v < 20; v++) begin
      if (vecs[v].nk == nk) begin
        e = base + vecs[v].round;
        if (e >= 64 || e >= n_st[d]) begin
          chk($sformatf("%s_r%0d_missing", tag, vecs[v].round), 128'(n_st[d]), 128'(e + 1));
        end else if (vecs[v].word < 0) begin
          chk($sformatf("%s_r%0d", tag, vecs[v].round), g_rk[d][e], vecs[v].exp);
          chk($sformatf("%s_r%0d_index", tag, vecs[v].round), 128'(g_ix[d][e]), 128'(vecs[v].round));
        end else begin
          chk($sformatf("%s_r%0d_w%0d", tag, vecs[v].round, vecs[v].word),
              128'(g_rk[d][e][32*vecs[v].word +: 32]), vecs[v].exp);
        end
      end
    end
  endtask

  task automatic clear_log(input int d);
    n_st[d]   = 0;
    n_done[d] = 0;
  endtask

  initial begin
    int  t0;
    bit  found;

    vecs[0]  = '{4,  0, -1, 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516};
    vecs[1]  = '{4,  1, -1, 128'h2a6c7605_23a33939_88542cb1_a0fafe17};
    vecs[2]  = '{4,  2, -1, 128'h7359f67f_5935807a_7a96b943_f2c295f2};
    vecs[3]  = '{4,  3, -1, 128'h6d7a883b_1e237e44_4716fe3e_3d80477d};
    vecs[4]  = '{4,  4, -1, 128'hdb0bad00_b671253b_a8525b7f_ef44a541};
    vecs[5]  = '{4,  5, -1, 128'h11f915bc_caf2b8bc_7c839d87_d4d1c6f8};
    vecs[6]  = '{4,  6, -1, 128'hca0093fd_dbf98641_110b3efd_6d88a37a};
    vecs[7]  = '{4,  7, -1, 128'h4ea6dc4f_84a64fb2_5f5fc9f3_4e54f70e};
    vecs[8]  = '{4,  8, -1, 128'h7f8d292f_312bf560_b58dbad2_ead27321};
    vecs[9]  = '{4,  9, -1, 128'h575c006e_28d12941_19fadc21_ac7766f3};
    vecs[10] = '{4, 10, -1, 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8};
    vecs[11] = '{6,  0, -1, 128'h809079e5_c810f32b_da0e6452_8e73b0f7};
    vecs[12] = '{6,  1,  0, 128'h62f8ead2};
    vecs[13] = '{6,  1,  1, 128'h522c6b7b};
    vecs[14] = '{6,  1,  2, 128'hfe0c91f7};
    vecs[15] = '{6, 12,  3, 128'h01002202};
    vecs[16] = '{8,  0, -1, 128'h857d7781_2b73aef0_15ca71be_603deb10};
    vecs[17] = '{8,  1, -1, 128'h0914dff4_2d9810a3_3b6108d7_1f352c07};
    vecs[18] = '{8,  2,  0, 128'h9ba35411};
    vecs[19] = '{8, 14,  3, 128'h706c631e};

    for (int d = 0; d < 3; d++) clear_log(d);
    bus4.start = 1'b0; bus4.key_in = KEY4;
    bus6.start = 1'b0; bus6.key_in = KEY6;
    bus8.start = 1'b0; bus8.key_in = KEY8;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_rk_out",   bus4.rk_out, 128'h0);
    chk("rst_rk_index", 128'(bus4.rk_index), 128'h0);
    chk("rst_rk_valid", 128'(bus4.rk_valid), 128'h0);
    chk("rst_busy",     128'(bus4.busy), 128'h0);
    chk("rst_done",     128'(bus4.done), 128'h0);
    chk("rst_state",    128'(st4), 128'h0);
    chk("rst_busy6",    128'(bus6.busy), 128'h0);
    chk("rst_busy8",    128'(bus8.busy), 128'h0);
    rst = 1'b0;
    tick();

    // NK=4: run 1, start held through the done cycle (ignored) and accepted at T+93,
    // run 2 sees start pulses with a different key at T2+10 and T2+50.
    clear_log(0);
    t0 = cyc;
    for (int c = 0; c <= 190; c++) begin
      bus4.start  = (c == 0) || (c == 92) || (c == 93) || (c == 103) || (c == 143);
      bus4.key_in = (c >= 103 && c <= 143) ? BOGUS : KEY4;
      if (c == 1)  chk("busy_t1", 128'(bus4.busy), 128'h1);
      if (c == 4) begin
        chk("hold_valid_t4", 128'(bus4.rk_valid), 128'h0);
        chk("hold_rk_t4", bus4.rk_out, vecs[0].exp);
      end
      if (c == 92) chk("busy_done_cycle", 128'(bus4.busy), 128'h1);
      if (c == 93) begin
        chk("busy_after_done", 128'(bus4.busy), 128'h0);
        chk("idle_after_done", 128'(st4), 128'h0);
      end
      if (c == 94) chk("busy_run2", 128'(bus4.busy), 128'h1);
      tick();
    end
    bus4.start = 1'b0;
    chk("b2b_strobes", 128'(n_st[0]), 128'd22);
    chk("b2b_done_cnt", 128'(n_done[0]), 128'd2);
    chk("run1_r0_time", 128'(g_cyc[0][0] - t0), 128'd2);
    chk("run1_r10_time", 128'(g_cyc[0][10] - t0), 128'd92);
    chk("run1_done_time", 128'(dcyc[0][0] - t0), 128'd92);
    chk("run2_r0_time", 128'(g_cyc[0][11] - t0), 128'd95);
    chk("run2_done_time", 128'(dcyc[0][1] - t0), 128'd185);
    apply_table(4, 0, 0, "run1");
    apply_table(4, 0, 11, "run2");

    // NK=4: reset after the round-4 strobe
    clear_log(0);
    bus4.key_in = KEY4;
    bus4.start  = 1'b1;
    t0 = cyc;
    tick();
    bus4.start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (n_st[0] >= 5) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("rst_mid_reached_r4", 128'(found), 128'h1);
    chk("r4_time", 128'(g_cyc[0][4] - t0), 128'd38);
    rst = 1'b1;
    tick();
    chk("mid_rst_rk_out",   bus4.rk_out, 128'h0);
    chk("mid_rst_rk_index", 128'(bus4.rk_index), 128'h0);
    chk("mid_rst_rk_valid", 128'(bus4.rk_valid), 128'h0);
    chk("mid_rst_busy",     128'(bus4.busy), 128'h0);
    chk("mid_rst_done",     128'(bus4.done), 128'h0);
    chk("mid_rst_state",    128'(st4), 128'h0);
    rst = 1'b0;
    repeat (100) tick();
    chk("mid_rst_no_strobes", 128'(n_st[0]), 128'd5);
    chk("mid_rst_no_done", 128'(n_done[0]), 128'd0);

    // NK=4: fresh start after reset
    clear_log(0);
    bus4.start = 1'b1;
    t0 = cyc;
    tick();
    bus4.start = 1'b0;
    repeat (100) tick();
    chk("after_rst_strobes", 128'(n_st[0]), 128'd11);
    chk("after_rst_done_time", 128'(dcyc[0][0] - t0), 128'd92);
    apply_table(4, 0, 0, "after_rst");

    // NK=6
    clear_log(1);
    bus6.start = 1'b1;
    t0 = cyc;
    tick();
    bus6.start = 1'b0;
    repeat (95) tick();
    chk("nk6_strobes", 128'(n_st[1]), 128'd13);
    chk("nk6_done_cnt", 128'(n_done[1]), 128'd1);
    chk("nk6_r0_time", 128'(g_cyc[1][0] - t0), 128'd2);
    chk("nk6_done_time", 128'(dcyc[1][0] - t0), 128'd88);
    chk("nk6_last_index", 128'(g_ix[1][12]), 128'd12);
    apply_table(6, 1, 0, "nk6");

    // NK=8
    clear_log(2);
    bus8.start = 1'b1;
    t0 = cyc;
    tick();
    bus8.start = 1'b0;
    repeat (125) tick();
    chk("nk8_strobes", 128'(n_st[2]), 128'd15);
    chk("nk8_done_cnt", 128'(n_done[2]), 128'd1);
    chk("nk8_r0_time", 128'(g_cyc[2][0] - t0), 128'd2);
    chk("nk8_r1_time", 128'(g_cyc[2][1] - t0), 128'd3);
    chk("nk8_done_time", 128'(dcyc[2][0] - t0), 128'd120);
    chk("nk8_last_index", 128'(g_ix[2][14]), 128'd14);
    apply_table(8, 2, 0, "nk8");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
